// File: rtl/frame_buffer_writer_if.sv
// Pixel-stream, RAM-write and status bundle for frame_buffer_writer; the checksum
// signal exists only when FBW_CHECKSUM_EN is defined.
interface frame_buffer_writer_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 8
);
   logic              start;
   logic              abort;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              busy;
   logic              frame_done;
   logic [9:0]        cur_x;
   logic [9:0]        cur_y;
`ifdef FBW_CHECKSUM_EN
   logic [15:0]       checksum;
`endif

   modport master (
      output start, abort, in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_data, busy, frame_done, cur_x, cur_y
`ifdef FBW_CHECKSUM_EN
      , input checksum
`endif
   );

   modport slave (
      input  start, abort, in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_data, busy, frame_done, cur_x, cur_y
`ifdef FBW_CHECKSUM_EN
      , output checksum
`endif
   );
endinterface

// File: rtl/frame_buffer_writer.sv
// Loads one column-major frame into image RAM (addr = x*IMG_H + y); write strobe 1 cycle after accept,
// in_ready decoded from state only. FBW_CHECKSUM_EN adds a 16-bit running pixel checksum.
module frame_buffer_writer #(
   parameter int IMG_W  = 300,
   parameter int IMG_H  = 300,
   parameter int ADDR_W = 18,
   parameter int DATA_W = 8
) (
   input logic                    clk,
   input logic                    rst_n,
   frame_buffer_writer_if.slave   bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [9:0]        Y_LAST    = 10'(IMG_H - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_W * IMG_H - 1);

   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic [9:0]        x_q;
   logic [9:0]        y_q;
   logic [ADDR_W-1:0] addr_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_data_q;
   logic              in_ready;
   logic              accept;
   logic              last_beat;

   assign in_ready  = (state_q == ST_WRITE);
   // A beat coinciding with abort is dropped, so abort gates the accept itself.
   assign accept    = in_ready && bus.in_valid && !bus.abort;
   assign last_beat = (addr_q == ADDR_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.start) state_d = ST_WRITE;
         ST_WRITE: begin
            if (bus.abort)
               state_d = ST_IDLE;
            else if (accept && last_beat)
               state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Counters hold on the final beat so addr never passes IMG_W*IMG_H-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q    <= '0;
         y_q    <= '0;
         addr_q <= '0;
      end else if (state_q == ST_IDLE && bus.start) begin
         x_q    <= '0;
         y_q    <= '0;
         addr_q <= '0;
      end else if (accept && !last_beat) begin
         addr_q <= addr_q + 1'b1;
         if (y_q == Y_LAST) begin
            y_q <= '0;
            x_q <= x_q + 1'b1;
         end else begin
            y_q <= y_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
      end else begin
         mem_we_q <= accept;
         if (accept) begin
            mem_addr_q <= addr_q;
            mem_data_q <= bus.in_data;
         end
      end
   end

`ifdef FBW_CHECKSUM_EN
   logic [15:0] checksum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         checksum_q <= '0;
      else if (state_q == ST_IDLE && bus.start)
         checksum_q <= '0;
      else if (accept)
         checksum_q <= checksum_q + 16'(bus.in_data);
   end

   assign bus.checksum = checksum_q;
`endif

   assign bus.in_ready   = in_ready;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_data   = mem_data_q;
   assign bus.busy       = (state_q == ST_WRITE) || (state_q == ST_DONE);
   assign bus.frame_done = (state_q == ST_DONE);
   assign bus.cur_x      = x_q;
   assign bus.cur_y      = y_q;

   a_we_after_accept: assert property (@(posedge clk) disable iff (!rst_n)
      mem_we_q |-> $past(accept));
   a_addr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
      addr_q <= ADDR_LAST);

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Scoreboard bench for frame_buffer_writer: a small frame model predicts writes and status,
// and a negedge monitor matches every write strobe against the expected queue.
module tb_frame_buffer_writer;

   localparam int IMG_W  = 8;
   localparam int IMG_H  = 300;
   localparam int ADDR_W = 18;
   localparam int DATA_W = 8;
   localparam int FRAME  = IMG_W * IMG_H;

   localparam int M_IDLE = 0;
   localparam int M_WR   = 1;
   localparam int M_DN   = 2;

   typedef struct {
      int addr;
      int data;
      int stamp;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   int   cyc;
   int   fd_count;
   exp_t sb[$];

   int          m_st;
   int          m_x;
   int          m_y;
   int          m_addr;
   logic [15:0] m_cks;

   frame_buffer_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   frame_buffer_writer #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // Write monitor: every strobe must match the oldest expected write, one cycle after its accept.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.frame_done) fd_count++;
         if (bus.mem_we) begin
            if (sb.size() == 0) begin
               chk("spurious_write", 32'(bus.mem_addr), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
               chk("wr_data", 32'(bus.mem_data), 32'(e.data));
               chk("wr_latency", 32'(cyc), 32'(e.stamp + 1));
            end
         end else if (sb.size() != 0 && sb[0].stamp + 1 == cyc) begin
            chk("missing_write", 32'(bus.mem_we), 32'd1);
            void'(sb.pop_front());
         end
      end
   end

   task automatic model_reset();
      m_st   = M_IDLE;
      m_x    = 0;
      m_y    = 0;
      m_addr = 0;
      m_cks  = '0;
   endtask

   // One cycle: check status against the model, drive inputs, advance the model, wait for next negedge.
   task automatic step(input logic s, input logic a, input logic v, input logic [7:0] d);
      exp_t e;
      chk("in_ready", 32'(bus.in_ready), 32'(m_st == M_WR));
      chk("busy", 32'(bus.busy), 32'(m_st != M_IDLE));
      chk("frame_done", 32'(bus.frame_done), 32'(m_st == M_DN));
      chk("cur_x", 32'(bus.cur_x), 32'(m_x));
      chk("cur_y", 32'(bus.cur_y), 32'(m_y));
`ifdef FBW_CHECKSUM_EN
      chk("checksum", 32'(bus.checksum), 32'(m_cks));
`endif
      bus.start    = s;
      bus.abort    = a;
      bus.in_valid = v;
      bus.in_data  = d;
      case (m_st)
         M_IDLE: if (s) begin
            m_x = 0; m_y = 0; m_addr = 0; m_cks = '0;
            m_st = M_WR;
         end
         M_WR: begin
            if (a) begin
               m_st = M_IDLE;
            end else if (v) begin
               e.addr = m_addr; e.data = int'(d); e.stamp = cyc;
               sb.push_back(e);
               m_cks = m_cks + 16'(d);
               if (m_addr == FRAME - 1) begin
                  m_st = M_DN;
               end else begin
                  m_addr++;
                  if (m_y == IMG_H - 1) begin
                     m_y = 0;
                     m_x++;
                  end else begin
                     m_y++;
                  end
               end
            end
         end
         default: m_st = M_IDLE;
      endcase
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
      chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
      chk({tag, "_mem_data"}, 32'(bus.mem_data), 32'd0);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
      chk({tag, "_cur_x"}, 32'(bus.cur_x), 32'd0);
      chk({tag, "_cur_y"}, 32'(bus.cur_y), 32'd0);
`ifdef FBW_CHECKSUM_EN
      chk({tag, "_checksum"}, 32'(bus.checksum), 32'd0);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      logic [15:0] cks_ref;
      n_chk = 0; n_fail = 0; cyc = 0; fd_count = 0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Full frame, data = addr mod 256, with an ignored start at pixel 10.
      step(1'b1, 1'b0, 1'b0, 8'h00);
      cks_ref = '0;
      for (int i = 0; i < FRAME; i++) begin
         step(i == 10, 1'b0, 1'b1, 8'(i % 256));
         cks_ref = cks_ref + 16'(i % 256);
         if (i == 298) begin
            chk("wrap299_x", 32'(bus.cur_x), 32'd0);
            chk("wrap299_y", 32'(bus.cur_y), 32'd299);
         end
         if (i == 299) begin
            chk("wrap300_x", 32'(bus.cur_x), 32'd1);
            chk("wrap300_y", 32'(bus.cur_y), 32'd0);
         end
      end
      chk("done_after_last", 32'(bus.frame_done), 32'd1);
`ifdef FBW_CHECKSUM_EN
      chk("checksum_frame1", 32'(bus.checksum), 32'(cks_ref));
`endif
      step(1'b0, 1'b1, 1'b0, 8'h00);  // abort in DONE has no effect
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("fd_count_frame1", 32'(fd_count), 32'd1);
      chk("busy_after_frame1", 32'(bus.busy), 32'd0);

      // Simultaneous start+abort in IDLE, then a frame with random valid gaps.
      step(1'b1, 1'b1, 1'b0, 8'h00);
      chk("start_abort_enters_write", 32'(bus.in_ready), 32'd1);
      guard = 0;
      while (m_st != M_DN && guard < 20000) begin
         step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
         guard++;
      end
      chk("gap_frame_bound", 32'(guard < 20000), 32'd1);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("fd_count_frame2", 32'(fd_count), 32'd2);

      // Abort at pixel 500 with a valid beat: beat dropped, counters frozen.
      step(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 500; i++) step(1'b0, 1'b0, 1'b1, 8'(i + 7));
      step(1'b0, 1'b1, 1'b1, 8'hAA);
      chk("abort_x_frozen", 32'(bus.cur_x), 32'd1);
      chk("abort_y_frozen", 32'(bus.cur_y), 32'd200);
      chk("abort_idle_ready", 32'(bus.in_ready), 32'd0);
      chk("abort_idle_busy", 32'(bus.busy), 32'd0);
      step(1'b0, 1'b0, 1'b1, 8'h55);  // valid in IDLE: no write
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("fd_count_abort", 32'(fd_count), 32'd2);

      // Restart from addr 0, then async reset mid-frame between edges.
      step(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1, 8'(i + 3));
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("midframe_addr_nonzero", 32'(bus.mem_addr), 32'd39);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_reset");
      sb.delete();
      model_reset();
      #1 rst_n = 1'b1;
      @(negedge clk);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'(8'hF0 + i));
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("post_reset_cur_y", 32'(bus.cur_y), 32'd5);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      chk("fd_count_final", 32'(fd_count), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
